// File: rtl/rv32i_pkg.sv
// Shared definitions for the rv32i boot path: widths, reset vector,
// boot sequencer state encoding and the image word address helper.
package rv32i_pkg;

  localparam int WORD_W         = 32;
  localparam int BYTE_W         = 8;
  localparam int BYTES_PER_WORD = WORD_W / BYTE_W;

  // Default byte address the core fetches from after reset.
  localparam logic [WORD_W-1:0] RST_VECTOR = 32'h0000_0000;

  typedef enum logic [2:0] {
    ST_HDR,
    ST_DATA,
    ST_WR,
    ST_CHK,
    ST_DLY,
    ST_RUN,
    ST_ERR
  } boot_state_t;

  // Byte address of image word idx; 32-bit modulo arithmetic on purpose.
  function automatic logic [WORD_W-1:0] word_addr(input logic [WORD_W-1:0] base,
                                                  input logic [WORD_W-1:0] idx);
    return base + (idx << 2);
  endfunction

endpackage

// File: rtl/rv32i_byte_packer.sv
// Little-endian 4-byte assembler. Bytes shift in from the top so the first
// byte ends up in bits 7:0. word/word_valid are presented combinationally in
// the cycle the 4th byte is accepted; clear discards any partial word.
module rv32i_byte_packer
  import rv32i_pkg::*;
(
  input  logic              clk,
  input  logic              srst,
  input  logic              clear,
  input  logic              byte_valid,
  input  logic [BYTE_W-1:0] byte_in,
  output logic [WORD_W-1:0] word,
  output logic              word_valid
);

  logic [1:0]        cnt_reg;
  logic [WORD_W-1:0] shift_reg;

  // Shift accepted bytes in and count them modulo four.
  always_ff @(posedge clk) begin
    if (srst || clear) begin
      cnt_reg   <= 2'd0;
      shift_reg <= '0;
    end else if (byte_valid) begin
      shift_reg <= {byte_in, shift_reg[WORD_W-1:BYTE_W]};
      cnt_reg   <= cnt_reg + 2'd1;
    end
  end

  assign word       = {byte_in, shift_reg[WORD_W-1:BYTE_W]};
  assign word_valid = byte_valid && !clear && (cnt_reg == 2'd3);

endmodule

// File: rtl/rv32i_boot_ctrl.sv
// Boot sequencer: holds the core in reset, receives a length-prefixed
// little-endian image over a byte stream, writes it to instruction memory
// from STARTUP_MEM_ADDR and releases the core after RELEASE_DLY cycles.
// Optional macro BOOT_CHECKSUM_EN adds a trailing XOR checksum word.
module rv32i_boot_ctrl
  import rv32i_pkg::*;
#(
  parameter logic [31:0] STARTUP_MEM_ADDR = RST_VECTOR,
  parameter int          MAX_WORDS        = 4096,
  parameter int          RELEASE_DLY      = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic        rx_ready_o,
  input  logic        boot_req_i,
  output logic        imem_we_o,
  output logic [31:0] imem_addr_o,
  output logic [31:0] imem_wdata_o,
  input  logic        imem_ready_i,
  output logic        core_rst_no,
  output logic        boot_done_o,
  output logic        err_o
);

  localparam int IDX_W = $clog2(MAX_WORDS + 1);

  boot_state_t       state_reg, state_next;
  logic [31:0]       n_reg;
  logic [IDX_W-1:0]  idx_reg;
  logic [7:0]        dly_cnt_reg;
  logic [31:0]       addr_reg;
  logic [31:0]       wdata_reg;
  logic              core_rst_n_reg;
  logic              boot_done_reg;
`ifdef BOOT_CHECKSUM_EN
  logic [31:0]       csum_reg;
`endif

  logic              byte_fire;
  logic [31:0]       word;
  logic              word_valid;
  logic              ack;
  logic              last_word;
  logic              dly_done;

  // A byte arriving together with boot_req_i is dropped.
  assign byte_fire = rx_valid_i && rx_ready_o && !boot_req_i;
  assign ack       = imem_we_o && imem_ready_i;
  assign last_word = (32'(idx_reg) + 32'd1) == n_reg;
  assign dly_done  = dly_cnt_reg == 8'(RELEASE_DLY - 1);

  rv32i_byte_packer u_packer (
    .clk        (clk_i),
    .srst       (rst_i),
    .clear      (boot_req_i),
    .byte_valid (byte_fire),
    .byte_in    (rx_data_i),
    .word       (word),
    .word_valid (word_valid)
  );

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg <= ST_HDR;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic; boot_req_i overrides the normal flow from any state.
  always_comb begin
    state_next = state_reg;
    if (boot_req_i) begin
      state_next = ST_HDR;
    end else begin
      case (state_reg)
        ST_HDR: begin
          if (word_valid) begin
            if (word == 32'd0) begin
              state_next = ST_DLY;
            end else if (word > 32'(MAX_WORDS)) begin
              state_next = ST_ERR;
            end else begin
              state_next = ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (word_valid) begin
            state_next = ST_WR;
          end
        end
        ST_WR: begin
          if (ack) begin
            if (last_word) begin
`ifdef BOOT_CHECKSUM_EN
              state_next = ST_CHK;
`else
              state_next = ST_DLY;
`endif
            end else begin
              state_next = ST_DATA;
            end
          end
        end
`ifdef BOOT_CHECKSUM_EN
        ST_CHK: begin
          if (word_valid) begin
            state_next = (word == csum_reg) ? ST_DLY : ST_ERR;
          end
        end
`endif
        ST_DLY: begin
          if (dly_done) begin
            state_next = ST_RUN;
          end
        end
        ST_RUN:  state_next = ST_RUN;
        ST_ERR:  state_next = ST_ERR;
        default: state_next = ST_HDR;
      endcase
    end
  end

  // Datapath: header capture, write address/data, word index, release delay
  // and the registered core release outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i || boot_req_i) begin
      n_reg          <= 32'd0;
      idx_reg        <= '0;
      dly_cnt_reg    <= 8'd0;
      addr_reg       <= STARTUP_MEM_ADDR;
      core_rst_n_reg <= 1'b0;
      boot_done_reg  <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
      csum_reg       <= 32'd0;
`endif
      if (rst_i) begin
        wdata_reg <= 32'd0;
      end
    end else begin
      core_rst_n_reg <= (state_reg == ST_RUN);
      boot_done_reg  <= (state_reg == ST_RUN);
      dly_cnt_reg    <= (state_reg == ST_DLY) ? dly_cnt_reg + 8'd1 : 8'd0;
      if (state_reg == ST_HDR && word_valid) begin
        n_reg   <= word;
        idx_reg <= '0;
`ifdef BOOT_CHECKSUM_EN
        csum_reg <= word;
`endif
      end
      if (state_reg == ST_DATA && word_valid) begin
        wdata_reg <= word;
        addr_reg  <= word_addr(STARTUP_MEM_ADDR, 32'(idx_reg));
`ifdef BOOT_CHECKSUM_EN
        csum_reg  <= csum_reg ^ word;
`endif
      end
      if (state_reg == ST_WR && ack) begin
        idx_reg <= idx_reg + IDX_W'(1);
      end
    end
  end

  assign rx_ready_o   = (state_reg == ST_HDR) || (state_reg == ST_DATA) ||
                        (state_reg == ST_CHK);
  assign imem_we_o    = (state_reg == ST_WR);
  assign err_o        = (state_reg == ST_ERR);
  assign imem_addr_o  = addr_reg;
  assign imem_wdata_o = wdata_reg;
  assign core_rst_no  = core_rst_n_reg;
  assign boot_done_o  = boot_done_reg;

endmodule

// File: tb/tb_rv32i_boot_ctrl.sv
// Self-checking bench for rv32i_boot_ctrl: directed image loads with a
// write scoreboard, stalled memory, boot restart, length error and reset.
module tb_rv32i_boot_ctrl;

  localparam int          MAXW = 8;
  localparam int          RDLY = 4;
  localparam logic [31:0] BASE = 32'h0000_0000;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [7:0]  rx_data_i;
  logic        rx_valid_i;
  logic        rx_ready_o;
  logic        boot_req_i;
  logic        imem_we_o;
  logic [31:0] imem_addr_o;
  logic [31:0] imem_wdata_o;
  logic        imem_ready_i;
  logic        core_rst_no;
  logic        boot_done_o;
  logic        err_o;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          stall = 0;
  int          last_ack_cyc = 0;
  int          writes_seen = 0;
  logic [31:0] csum_acc = 32'd0;
  logic [63:0] exp_q[$];

  rv32i_boot_ctrl #(
    .STARTUP_MEM_ADDR (BASE),
    .MAX_WORDS        (MAXW),
    .RELEASE_DLY      (RDLY)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .rx_data_i    (rx_data_i),
    .rx_valid_i   (rx_valid_i),
    .rx_ready_o   (rx_ready_o),
    .boot_req_i   (boot_req_i),
    .imem_we_o    (imem_we_o),
    .imem_addr_o  (imem_addr_o),
    .imem_wdata_o (imem_wdata_o),
    .imem_ready_i (imem_ready_i),
    .core_rst_no  (core_rst_no),
    .boot_done_o  (boot_done_o),
    .err_o        (err_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every cycle with a write request is compared to the head
  // of the expected-write queue; the entry is retired on the acknowledge.
  always @(negedge clk_i) begin
    if (rst_i === 1'b0 && imem_we_o === 1'b1) begin
      $display("cyc %0d write addr=%h data=%h ready=%b", cyc, imem_addr_o, imem_wdata_o, imem_ready_i);
      chk("wr_rx_ready", 32'(rx_ready_o), 32'd0);
      chk("wr_expected_pending", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        chk("wr_addr", imem_addr_o, exp_q[0][63:32]);
        chk("wr_data", imem_wdata_o, exp_q[0][31:0]);
        if (imem_ready_i) begin
          void'(exp_q.pop_front());
          last_ack_cyc = cyc;
          writes_seen++;
        end
      end
    end
  end

  // Memory responder: acknowledges after 'stall' wait cycles per write.
  initial begin
    int wcnt;
    wcnt = 0;
    imem_ready_i = 1'b0;
    forever begin
      @(posedge clk_i);
      #1;
      if (imem_we_o) begin
        imem_ready_i = (wcnt >= stall);
        wcnt++;
      end else begin
        imem_ready_i = 1'b0;
        wcnt = 0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b);
    int n;
    rx_data_i  = b;
    rx_valid_i = 1'b1;
    for (n = 0; n < 100; n++) begin
      @(negedge clk_i);
      if (rx_ready_o) break;
    end
    if (n >= 100) chk("rx_ready_timeout", 32'(rx_ready_o), 32'd1);
    @(posedge clk_i);
    #1;
    rx_valid_i = 1'b0;
  endtask

  task automatic send_word_bytes(input logic [31:0] w);
    send_byte(w[7:0]);
    send_byte(w[15:8]);
    send_byte(w[23:16]);
    send_byte(w[31:24]);
  endtask

  task automatic send_hdr(input logic [31:0] n);
    $display("cyc %0d header N=%0d", cyc, n);
    csum_acc = n;
    send_word_bytes(n);
  endtask

  task automatic send_data_word(input logic [31:0] w, input logic [31:0] a);
    exp_q.push_back({a, w});
    csum_acc = csum_acc ^ w;
    send_word_bytes(w);
  endtask

  // Wait for core release and check its distance from the reference event:
  // last acknowledge (+RDLY+2 sampled cycles) or last accepted byte (+RDLY+1).
  task automatic wait_release(input string tag, input bit use_ack, input int ref_cyc);
    int n;
    int delta;
    for (n = 0; n < 200; n++) begin
      @(negedge clk_i);
      if (core_rst_no) break;
    end
    chk({tag, "_core_rst_no"}, 32'(core_rst_no), 32'd1);
    chk({tag, "_boot_done"}, 32'(boot_done_o), 32'd1);
    chk({tag, "_rx_ready_run"}, 32'(rx_ready_o), 32'd0);
    chk({tag, "_err"}, 32'(err_o), 32'd0);
    delta = use_ack ? (cyc - last_ack_cyc) : (cyc - ref_cyc);
    chk({tag, "_release_delay"}, delta, use_ack ? (RDLY + 2) : (RDLY + 1));
    chk({tag, "_queue_empty"}, exp_q.size(), 32'd0);
    $display("cyc %0d release %s delta=%0d", cyc, tag, delta);
  endtask

  task automatic finish_image(input string tag);
`ifdef BOOT_CHECKSUM_EN
    send_word_bytes(csum_acc);
    wait_release(tag, 1'b0, cyc);
`else
    wait_release(tag, 1'b1, 0);
`endif
  endtask

  task automatic pulse_boot_req(input bit with_byte, input logic [7:0] b);
    boot_req_i = 1'b1;
    if (with_byte) begin
      rx_valid_i = 1'b1;
      rx_data_i  = b;
    end
    @(posedge clk_i);
    #1;
    boot_req_i = 1'b0;
    rx_valid_i = 1'b0;
    $display("cyc %0d boot_req", cyc);
    chk("breq_core_rst_no", 32'(core_rst_no), 32'd0);
    chk("breq_boot_done", 32'(boot_done_o), 32'd0);
    chk("breq_err", 32'(err_o), 32'd0);
    chk("breq_we", 32'(imem_we_o), 32'd0);
    chk("breq_rx_ready", 32'(rx_ready_o), 32'd1);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_rx_ready"}, 32'(rx_ready_o), 32'd1);
    chk({tag, "_we"}, 32'(imem_we_o), 32'd0);
    chk({tag, "_addr"}, imem_addr_o, BASE);
    chk({tag, "_wdata"}, imem_wdata_o, 32'd0);
    chk({tag, "_core_rst_no"}, 32'(core_rst_no), 32'd0);
    chk({tag, "_boot_done"}, 32'(boot_done_o), 32'd0);
    chk({tag, "_err"}, 32'(err_o), 32'd0);
  endtask

  initial begin
    int t0;
    int ws;
    rst_i      = 1'b1;
    rx_data_i  = 8'h00;
    rx_valid_i = 1'b0;
    boot_req_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    check_reset_values("reset");
    rst_i = 1'b0;

    // Two-word image, immediate acknowledge.
    stall = 0;
    send_hdr(32'd2);
    send_data_word(32'h1234_5678, BASE + 32'h0);
    send_data_word(32'hDEAD_BEEF, BASE + 32'h4);
    finish_image("img2");

    // Same image with three wait cycles per write; the next byte is
    // offered while the write stalls and must not be consumed.
    pulse_boot_req(1'b0, 8'h00);
    stall = 3;
    send_hdr(32'd2);
    send_data_word(32'h1234_5678, BASE + 32'h0);
    send_data_word(32'hDEAD_BEEF, BASE + 32'h4);
    finish_image("img2_stall");
    stall = 0;

    // Empty image: no writes, release after the delay.
    pulse_boot_req(1'b0, 8'h00);
    ws = writes_seen;
    send_hdr(32'd0);
    t0 = cyc;
    wait_release("empty", 1'b0, t0);
    chk("empty_no_writes", writes_seen, ws);

    // Oversized header: error, no writes, core stays in reset.
    pulse_boot_req(1'b0, 8'h00);
    send_hdr(32'(MAXW + 1));
    repeat (3) @(posedge clk_i);
    #1;
    chk("len_err_err", 32'(err_o), 32'd1);
    chk("len_err_rx_ready", 32'(rx_ready_o), 32'd0);
    chk("len_err_core_rst_no", 32'(core_rst_no), 32'd0);
    chk("len_err_no_writes", writes_seen, ws);
    pulse_boot_req(1'b0, 8'h00);

    // Full-capacity image is legal.
    for (int i = 0; i < MAXW; i++) begin
      if (i == 0) send_hdr(32'(MAXW));
      send_data_word($urandom, BASE + 32'(4 * i));
    end
    finish_image("full");

    // Restart from RUN, partial header, then a byte dropped under boot_req.
    pulse_boot_req(1'b0, 8'h00);
    send_byte(8'hAA);
    send_byte(8'hBB);
    pulse_boot_req(1'b1, 8'h55);
    send_hdr(32'd1);
    send_data_word(32'hCAFE_F00D, BASE + 32'h0);
    finish_image("reload");

    // Reset in the middle of a data word.
    pulse_boot_req(1'b0, 8'h00);
    send_hdr(32'd2);
    send_byte(8'h11);
    send_byte(8'h22);
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    check_reset_values("mid_rst");
    send_hdr(32'd1);
    send_data_word(32'h0000_0013, BASE + 32'h0);
    finish_image("after_rst");

`ifdef BOOT_CHECKSUM_EN
    // Bad checksum: image written but the core is held with err_o set.
    pulse_boot_req(1'b0, 8'h00);
    send_hdr(32'd1);
    send_data_word(32'h0000_0013, BASE + 32'h0);
    chk("csum_model", csum_acc, 32'h0000_0012);
    send_word_bytes(32'h0000_0000);
    repeat (2) @(posedge clk_i);
    #1;
    chk("csum_bad_err", 32'(err_o), 32'd1);
    chk("csum_bad_core_rst_no", 32'(core_rst_no), 32'd0);
    chk("csum_bad_rx_ready", 32'(rx_ready_o), 32'd0);
    pulse_boot_req(1'b0, 8'h00);
`endif

    repeat (2) @(posedge clk_i);
    #1;
    chk("final_queue_empty", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
